// File: rtl/sudoku_pkg.sv
// Shared Sudoku board definitions: geometry, traversal order codes,
// reader FSM states and the cell legality helper.
package sudoku_pkg;

    localparam int N        = 9;
    localparam int BOX      = 3;
    localparam int CELL_W   = 4;
    localparam int CELL_MAX = 9;

    localparam logic [1:0] ORD_ROW = 2'd0;
    localparam logic [1:0] ORD_COL = 2'd1;
    localparam logic [1:0] ORD_BOX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_SEND = 2'd3
    } rd_state_e;

    // A cell is illegal when it exceeds the largest Sudoku digit.
    function automatic logic cell_is_illegal(input logic [7:0] value);
        return (value > 8'(CELL_MAX));
    endfunction

endpackage

// File: rtl/sudoku_board_reader_if.sv
// Valid/ready cell stream carrying board cells plus group/end markers.
interface sudoku_board_reader_if #(
    parameter int CELL_W = 4
) ();
    logic [CELL_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_sog;
    logic              tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_sog,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_sog,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/sudoku_scan_addr.sv
// Group/position scan counter with order-dependent row/column mapping.
// Shared between the board reader and the row/column/box checker.
module sudoku_scan_addr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic [1:0] order_i,
    output logic       first_o,
    output logic       last_o,
    output logic [3:0] row_o,
    output logic [3:0] col_o
);
    import sudoku_pkg::*;

    localparam logic [3:0] LAST_POS = 4'(N - 1);
    localparam logic [3:0] BOX_W    = 4'(BOX);

    logic [3:0] g_q, g_d;
    logic [3:0] p_q, p_d;
    logic [3:0] g_div_s, g_mod_s, p_div_s, p_mod_s;

    // Next-state of the counters: clear, advance with 8->0 wrap, or hold.
    always_comb begin
        g_d = g_q;
        p_d = p_q;
        if (clr_i) begin
            g_d = 4'd0;
            p_d = 4'd0;
        end else if (adv_i) begin
            if (p_q == LAST_POS) begin
                p_d = 4'd0;
                g_d = g_q + 4'd1;
            end else begin
                p_d = p_q + 4'd1;
            end
        end else begin
            g_d = g_q;
            p_d = p_q;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_q <= 4'd0;
            p_q <= 4'd0;
        end else begin
            g_q <= g_d;
            p_q <= p_d;
        end
    end

    assign g_div_s = g_q / BOX_W;
    assign g_mod_s = g_q % BOX_W;
    assign p_div_s = p_q / BOX_W;
    assign p_mod_s = p_q % BOX_W;

    // Map (group, position) to a board address for the latched order.
    always_comb begin
        row_o = g_q;
        col_o = p_q;
        case (order_i)
            ORD_COL: begin
                row_o = p_q;
                col_o = g_q;
            end
            ORD_BOX: begin
                row_o = (BOX_W * g_div_s) + p_div_s;
                col_o = (BOX_W * g_mod_s) + p_mod_s;
            end
            default: begin
                row_o = g_q;
                col_o = p_q;
            end
        endcase
    end

    assign first_o = (p_q == 4'd0);
    assign last_o  = (g_q == LAST_POS) && (p_q == LAST_POS);

endmodule

// File: rtl/sudoku_board_reader.sv
// Board dump engine: walks all 81 cells in row, column or box order,
// reads each through the board read port and streams it out with
// start-of-group and end-of-board markers.
module sudoku_board_reader #(
    parameter int CELL_W = sudoku_pkg::CELL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            order,
    output logic                  rd_en,
    output logic [3:0]            rd_row,
    output logic [3:0]            rd_col,
    input  logic [CELL_W-1:0]     rd_data,
    sudoku_board_reader_if.master tx,
    output logic                  busy,
    output logic                  done,
    output logic                  bad_cell
);
    import sudoku_pkg::*;

    rd_state_e         state_q, state_d;
    logic [1:0]        order_q;
    logic [CELL_W-1:0] tx_data_q;
    logic              sog_q;
    logic              last_q;
    logic              done_q;
    logic              bad_q;

    logic              clr_s;
    logic              adv_s;
    logic              first_s;
    logic              last_s;
    logic [3:0]        row_s;
    logic [3:0]        col_s;

    sudoku_scan_addr u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr_s),
        .adv_i   (adv_s),
        .order_i (order_q),
        .first_o (first_s),
        .last_o  (last_s),
        .row_o   (row_s),
        .col_o   (col_s)
    );

    // FSM next state plus scan counter clear/advance strobes.
    always_comb begin
        state_d = state_q;
        clr_s   = 1'b0;
        adv_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: state_d = ST_SEND;
            ST_SEND: begin
                if (tx.tx_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                        adv_s   = 1'b1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched order, tx register slice and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            order_q   <= ORD_ROW;
            tx_data_q <= '0;
            sog_q     <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        order_q <= order;
                        done_q  <= 1'b0;
                        bad_q   <= 1'b0;
                    end
                end
                ST_CAPT: begin
                    tx_data_q <= rd_data;
                    sog_q     <= first_s;
                    last_q    <= last_s;
                    if (cell_is_illegal(8'(rd_data))) begin
                        bad_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tx.tx_ready && last_q) begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_en       = (state_q == ST_READ);
    assign rd_row      = rd_en ? row_s : 4'd0;
    assign rd_col      = rd_en ? col_s : 4'd0;
    assign tx.tx_valid = (state_q == ST_SEND);
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_sog   = tx.tx_valid & sog_q;
    assign tx.tx_last  = tx.tx_valid & last_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign bad_cell    = bad_q;

endmodule

// File: tb/tb_sudoku_board_reader.sv
// Table-driven bench for the Sudoku board reader with a registered
// board read-port model and hand-written reset/abort sequences.
module tb_sudoku_board_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] order;
    logic       rd_en;
    logic [3:0] rd_row, rd_col;
    logic [3:0] rd_data;
    logic       busy, done, bad_cell;

    logic [3:0] board [9][9];

    sudoku_board_reader_if #(.CELL_W(4)) tx_if ();

    sudoku_board_reader #(.CELL_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .order    (order),
        .rd_en    (rd_en),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_data  (rd_data),
        .tx       (tx_if),
        .busy     (busy),
        .done     (done),
        .bad_cell (bad_cell)
    );

    always #5 clk = ~clk;

    // Registered board read port: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= board[rd_row][rd_col];
    end

    typedef struct {
        int order;
        int pattern;     // 0: (r+c)%9+1, 1: all 0 except (4,4)=12
        int ready_mode;  // 0: always ready, 1: 5-cycle stall at beat 40 then random
        int mid_start;   // pulse start with a different order at beat 20
        int exp_cycles;  // cycle where done is first seen, 0 = not checked
        int exp_bad;
        int exp_bad_beat;
        int exp_first;
        int exp_last;
        int exp_sum;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run observations.
    int beats, done_cyc, addr_err, data_err, sog_err, last_err;
    int stab_err, zero_err, busy_err, bad_beat, sum, first_data, last_data;
    int timeout;
    int log_r [81];
    int log_c [81];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic exp_rc(input int ord, input int i, output int r, output int c);
        int g, p;
        g = i / 9;
        p = i % 9;
        if (ord == 1) begin
            r = p; c = g;
        end else if (ord == 2) begin
            r = 3 * (g / 3) + p / 3;
            c = 3 * (g % 3) + p % 3;
        end else begin
            r = g; c = p;
        end
    endtask

    task automatic fill_board(input int pattern);
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                if (pattern == 0) board[r][c] = 4'((r + c) % 9 + 1);
                else              board[r][c] = 4'd0;
            end
        end
        if (pattern == 1) board[4][4] = 4'd12;
    endtask

    // Start a dump and observe it cycle by cycle at the falling edge.
    task automatic run_dump(input int ord, input int mode, input int mid_start, input int abort_at);
        int cyc, rd_idx, er, ec, stall_left;
        bit stall_done, ms_done, pv, pr, ps, pl, fin;
        logic [3:0] pd;
        cyc = 0; rd_idx = 0; stall_left = 0;
        stall_done = 0; ms_done = 0; pv = 0; pr = 0; ps = 0; pl = 0; pd = 4'd0; fin = 0;
        beats = 0; done_cyc = -1; addr_err = 0; data_err = 0; sog_err = 0; last_err = 0;
        stab_err = 0; zero_err = 0; busy_err = 0; bad_beat = -1; sum = 0;
        first_data = -1; last_data = -1; timeout = 0;
        @(negedge clk);
        order = 2'(ord);
        start = 1'b1;
        tx_if.tx_ready = 1'b1;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            // Drive tx_ready for the coming edge.
            if (mode == 1 && !stall_done && tx_if.tx_valid && beats == 40) begin
                stall_done = 1;
                stall_left = 5;
            end
            if (mode == 0) begin
                tx_if.tx_ready = 1'b1;
            end else if (stall_left > 0) begin
                tx_if.tx_ready = 1'b0;
                stall_left--;
            end else if (stall_done) begin
                tx_if.tx_ready = 1'($urandom_range(0, 1));
            end else begin
                tx_if.tx_ready = 1'b1;
            end
            if (mid_start != 0 && !ms_done && tx_if.tx_valid && beats == 20) begin
                ms_done = 1;
                start = 1'b1;
                order = 2'(ord == 1 ? 2 : 1);
            end
            // Read port address sequence.
            if (rd_en) begin
                exp_rc(ord, rd_idx, er, ec);
                if (rd_idx < 81) begin
                    log_r[rd_idx] = int'(rd_row);
                    log_c[rd_idx] = int'(rd_col);
                end
                if (int'(rd_row) != er || int'(rd_col) != ec) addr_err++;
                rd_idx++;
            end else if (rd_row != 4'd0 || rd_col != 4'd0) begin
                zero_err++;
            end
            if (!tx_if.tx_valid && (tx_if.tx_sog || tx_if.tx_last)) zero_err++;
            if (pv && !pr) begin
                if (!tx_if.tx_valid || tx_if.tx_data != pd || tx_if.tx_sog != ps || tx_if.tx_last != pl)
                    stab_err++;
            end
            if (bad_cell && bad_beat < 0) bad_beat = beats;
            if (!busy && !done) busy_err++;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                exp_rc(ord, beats, er, ec);
                if (beats < 81) begin
                    if (tx_if.tx_data != board[er][ec]) data_err++;
                end else begin
                    data_err++;
                end
                if (tx_if.tx_sog != (beats % 9 == 0)) sog_err++;
                if (tx_if.tx_last != (beats == 80)) last_err++;
                sum += int'(tx_if.tx_data);
                if (beats == 0) first_data = int'(tx_if.tx_data);
                last_data = int'(tx_if.tx_data);
                beats++;
            end
            pv = tx_if.tx_valid; pr = tx_if.tx_ready;
            pd = tx_if.tx_data; ps = tx_if.tx_sog; pl = tx_if.tx_last;
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end else if (abort_at >= 0 && beats == abort_at) begin
                fin = 1;
            end else if (cyc > 3000) begin
                timeout = 1;
                fin = 1;
            end
        end
        tx_if.tx_ready = 1'b1;
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 0, 0, 0, 244, 0, -1, 1, 8, 405};
        vecs[1] = '{1, 0, 0, 0, 244, 0, -1, 1, 8, 405};
        vecs[2] = '{2, 0, 0, 0, 244, 0, -1, 1, 8, 405};
        vecs[3] = '{3, 0, 0, 0, 244, 0, -1, 1, 8, 405};
        vecs[4] = '{0, 0, 1, 0,   0, 0, -1, 1, 8, 405};
        vecs[5] = '{0, 1, 0, 0, 244, 1, 40, 0, 0, 12};
        vecs[6] = '{2, 1, 0, 0, 244, 1, 40, 0, 0, 12};
        vecs[7] = '{0, 0, 0, 1, 244, 0, -1, 1, 8, 405};

        rst_n = 1'b0; start = 1'b0; order = 2'd0; tx_if.tx_ready = 1'b0;
        fill_board(0);
        repeat (3) @(negedge clk);
        check("rst_rd_en",    int'(rd_en), 0);
        check("rst_tx_valid", int'(tx_if.tx_valid), 0);
        check("rst_busy",     int'(busy), 0);
        check("rst_done",     int'(done), 0);
        check("rst_bad",      int'(bad_cell), 0);
        check("rst_tx_data",  int'(tx_if.tx_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            fill_board(vecs[k].pattern);
            run_dump(vecs[k].order, vecs[k].ready_mode, vecs[k].mid_start, -1);
            check($sformatf("v%0d_timeout", k), timeout, 0);
            check($sformatf("v%0d_beats", k), beats, 81);
            check($sformatf("v%0d_addr", k), addr_err, 0);
            check($sformatf("v%0d_data", k), data_err, 0);
            check($sformatf("v%0d_sog", k), sog_err, 0);
            check($sformatf("v%0d_last", k), last_err, 0);
            check($sformatf("v%0d_stable", k), stab_err, 0);
            check($sformatf("v%0d_zero", k), zero_err, 0);
            check($sformatf("v%0d_busy", k), busy_err, 0);
            check($sformatf("v%0d_done", k), int'(done), 1);
            check($sformatf("v%0d_bad", k), int'(bad_cell), vecs[k].exp_bad);
            check($sformatf("v%0d_bad_beat", k), bad_beat, vecs[k].exp_bad_beat);
            check($sformatf("v%0d_first", k), first_data, vecs[k].exp_first);
            check($sformatf("v%0d_lastval", k), last_data, vecs[k].exp_last);
            check($sformatf("v%0d_sum", k), sum, vecs[k].exp_sum);
            if (vecs[k].exp_cycles != 0)
                check($sformatf("v%0d_cycles", k), done_cyc, vecs[k].exp_cycles);
            if (vecs[k].order == 2) begin
                check($sformatf("v%0d_box9", k),  log_r[9] * 16 + log_c[9], 3);
                check($sformatf("v%0d_box27", k), log_r[27] * 16 + log_c[27], 48);
                check($sformatf("v%0d_box80", k), log_r[80] * 16 + log_c[80], 136);
            end
        end

        // Reset in the middle of a dump, then a fresh complete dump.
        fill_board(0);
        run_dump(0, 0, 0, 50);
        check("abort_beats", beats, 50);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_rd_en",  int'(rd_en), 0);
        check("mid_rst_addr",   int'(rd_row) + int'(rd_col), 0);
        check("mid_rst_valid",  int'(tx_if.tx_valid), 0);
        check("mid_rst_marks",  int'(tx_if.tx_sog) + int'(tx_if.tx_last), 0);
        check("mid_rst_data",   int'(tx_if.tx_data), 0);
        check("mid_rst_busy",   int'(busy), 0);
        check("mid_rst_done",   int'(done), 0);
        check("mid_rst_bad",    int'(bad_cell), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_done", int'(done), 0);
        run_dump(0, 0, 0, -1);
        check("fresh_timeout", timeout, 0);
        check("fresh_beats",   beats, 81);
        check("fresh_addr",    addr_err, 0);
        check("fresh_data",    data_err, 0);
        check("fresh_first",   first_data, 1);
        check("fresh_cycles",  done_cyc, 244);
        check("fresh_done",    int'(done), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sudoku_board_reader.md
# sudoku_board_reader

Read-out engine for the 9x9 Sudoku board register array: the counterpart to the serial cell loader. On a start pulse it walks all 81 cells in a selectable order (row-, column- or box-major), fetches each cell through the board's read port, and transmits it on a valid/ready stream with group and end-of-board markers. It sits between the board storage and the chip-level output mux and gives the host a verified dump of the loaded puzzle.

## Interface
Parameters:
- CELL_W, 4, cell value width. Must match board storage.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request a dump; sampled only in IDLE
- order  in  2  traversal order: 0 row-major, 1 column-major, 2 box-major, 3 treated as row-major; latched when start is accepted
- rd_en  out  1  board read strobe
- rd_row  out  4  board read row, 0..8
- rd_col  out  4  board read column, 0..8
- rd_data  in  CELL_W  cell value, valid the cycle after rd_en
- tx_data  out  CELL_W  transmitted cell value
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts when high with tx_valid
- tx_sog  out  1  start of group: first cell of a row, column or box
- tx_last  out  1  final cell, index 80
- busy  out  1  dump in progress
- done  out  1  sticky; dump completed
- bad_cell  out  1  sticky; some transmitted value was greater than 9

## Operation
- Index i = 0..80 is split into group g = i/9 and position p = i%9.
- Address mapping:
  - Row-major: row = g, col = p.
  - Column-major: row = p, col = g.
  - Box-major: row = 3*(g/3) + p/3, col = 3*(g%3) + p%3.
- FSM states IDLE, READ, CAPT, SEND.
  - IDLE: start=1 latches order, clears g, p, done and bad_cell, and moves to READ. Otherwise stays in IDLE.
  - READ: rd_en=1 with rd_row/rd_col for the current (g,p). Next state CAPT.
  - CAPT: rd_data is registered into tx_data. tx_sog = (p==0) and tx_last = (i==80) are registered. bad_cell is set if rd_data > 9. Next state SEND.
  - SEND: tx_valid=1. On tx_valid & tx_ready:
    - If i==80: go to IDLE with done=1.
    - Otherwise: advance p, wrapping 8→0 and incrementing g, then go to READ.
  - Without ready the block stays in SEND.
- tx_data, tx_sog and tx_last are held stable while tx_valid=1 and tx_ready=0.
- tx_sog and tx_last are meaningful only while tx_valid=1 and are 0 otherwise.
- start while busy is ignored; order changes while busy are ignored.
- tx_ready while tx_valid=0 has no effect.
- Values 10–15 are transmitted unchanged; they only set bad_cell.
- Value 0 (empty cell) is transmitted as 0 and is not an error.
- busy = (state != IDLE).
- rd_row and rd_col are 0 whenever rd_en=0.

## Timing
- Reset values: all outputs 0; state IDLE; g = p = 0.
- Reset mid-dump: next cycle is IDLE with all outputs 0. A partial dump is not resumed and done stays 0.
- Cycle 0 = start sampled high in IDLE. READ is cycle 1, CAPT cycle 2, first tx_valid in cycle 3.
- With tx_ready held high: one cell per 3 cycles; handshakes in cycles 3, 6, …, 243. busy falls and done rises in cycle 244.
- Each cycle of tx_ready=0 in SEND adds one cycle of stall.
- start may be reasserted in cycle 244 or later. Its acceptance clears done one cycle later.
- rd_data is sampled exactly one cycle after rd_en. The board read port must be registered or a stable combinational read.

## Structure
- Shared package sudoku_pkg holds:
  - Board constants N=9, BOX=3, CELL_W=4.
  - Order encodings ORD_ROW=0, ORD_COL=1, ORD_BOX=2.
  - The reader state enum.
  - The max legal cell value 9, also used by the checker.
- Sub-module sudoku_scan_addr: holds the g/p counters (clear, advance, wrap), the i==80 flag and the order-dependent row/col mapping. It is reusable by the row/column/box checker.
- The top module contains the FSM, the tx register slice and the sticky flags.

## Test plan
- Row-major, ready held high; board cell (r,c) = (r+c)%9+1 → 81 beats in cycles 3..243 in row-major order. tx_sog on i = 0, 9, …, 72. tx_last only on i=80. done=1 from cycle 244. bad_cell=0.
- Column-major and box-major on the same board → rd_row/rd_col sequences match the mapping. Box-major beat 9 reads (0,3); beat 27 reads (3,0); beat 80 reads (8,8).
- tx_ready low for 5 cycles at beat 40, then random toggling → no lost or duplicated beat. tx_data, tx_sog and tx_last are stable during each stall. Total beats = 81.
- Cell (4,4) = 12 and all others 0 → 81 beats all 0 except 12 at row-major i=40. bad_cell rises the cycle after that CAPT. done=1 at end.
- start pulsed at beat 20 with order changed → ignored: the dump completes in the original order and busy stays high.
- rst_n low for one cycle at beat 50 → all outputs 0 the next cycle, state IDLE, done=0. A fresh start then produces a complete 81-beat dump from i=0.
